// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and fault causes for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {C_NONE, C_MISALIGN, C_ILLEGAL, C_TIMEOUT} cause_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/strobe generation, load extraction/extension and op legality checks
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_misaligned,
    output logic        o_illegal
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign o_load = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                    (i_funct3 == F3_BU) ? {24'd0, w_byte} :
                    (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                    (i_funct3 == F3_HU) ? {16'd0, w_half} : i_rdata;
    assign o_wstrb = (i_funct3[1:0] == 2'b00) ? 4'b0001 << i_addr :
                     (i_funct3[1:0] == 2'b01) ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign o_wdata = (i_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
                     (i_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
    assign o_misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                          (i_funct3[1:0] == 2'b10 && i_addr != 2'b00);
    assign o_illegal = i_store ? (i_funct3 > F3_W) :
                       !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding req/gnt/rvalid memory stage with alignment faults and bus timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata_in,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_load_data,
    output logic        o_lsu_done,
    output logic        o_lsu_stall,
    output logic        o_lsu_fault,
    output logic [1:0]  o_fault_cause
);
    state_t      r_state, w_next;
    cause_t      r_cause, w_cause;
    logic [2:0]  r_f3;
    logic [1:0]  r_addr_lo;
    logic        r_store;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0] r_load;
    logic        r_req, r_we;
    logic [31:0] r_maddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_idle, w_accept, w_bad, w_mis, w_ill, w_rd_hit, w_tmo;
    logic [3:0]  w_strb;
    logic [31:0] w_lane, w_ext;

    assign w_idle   = r_state == S_IDLE;
    assign w_accept = w_idle && i_start && (i_mem_read || i_mem_write);
    assign w_bad    = w_ill || (i_mem_read && i_mem_write);
    assign w_tmo    = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_rd_hit = i_mem_rvalid && ((r_state == S_REQ && i_mem_gnt && !r_store) || r_state == S_WAIT);

    // Legality is judged on the live inputs in IDLE; extension uses the captured op afterwards.
    lsu_align u_align (
        .i_funct3     (w_idle ? i_funct3 : r_f3),
        .i_store      (w_idle ? i_mem_write : r_store),
        .i_addr       (w_idle ? i_addr[1:0] : r_addr_lo),
        .i_wdata      (i_wdata_in),
        .i_rdata      (i_mem_rdata),
        .o_wstrb      (w_strb),
        .o_wdata      (w_lane),
        .o_load       (w_ext),
        .o_misaligned (w_mis),
        .o_illegal    (w_ill)
    );

    always_comb begin
        w_next  = r_state;
        w_cause = C_NONE;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_next  = (w_bad || w_mis) ? S_RESP : S_REQ;
                w_cause = w_bad ? C_ILLEGAL : w_mis ? C_MISALIGN : C_NONE;
            end
            S_REQ:  if (i_mem_gnt) w_next = (r_store || i_mem_rvalid) ? S_RESP : S_WAIT;
            S_WAIT: if (i_mem_rvalid || w_tmo) begin
                w_next  = S_RESP;
                w_cause = i_mem_rvalid ? C_NONE : C_TIMEOUT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cause   <= C_NONE;
            r_f3      <= '0;
            r_addr_lo <= '0;
            r_store   <= 1'b0;
            r_cnt     <= '0;
            r_load    <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_maddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_next == S_RESP && r_state != S_RESP) r_cause <= w_cause;
            if (w_rd_hit) r_load <= w_ext;
            if (w_accept) begin
                r_f3      <= i_funct3;
                r_addr_lo <= i_addr[1:0];
                r_store   <= i_mem_write;
            end
            if (w_idle && w_next == S_REQ) begin
                r_req   <= 1'b1;
                r_we    <= i_mem_write;
                r_maddr <= {i_addr[31:2], 2'b00};
                r_wdata <= i_mem_write ? w_lane : '0;
                r_wstrb <= i_mem_write ? w_strb : '0;
            end else if (r_state == S_REQ && i_mem_gnt) begin
                r_req   <= 1'b0;
                r_we    <= 1'b0;
                r_maddr <= '0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end
        end
    end

    assign o_mem_req     = r_req;
    assign o_mem_we      = r_we;
    assign o_mem_addr    = r_maddr;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_wstrb   = r_wstrb;
    assign o_load_data   = r_load;
    assign o_lsu_done    = r_state == S_RESP;
    assign o_lsu_fault   = o_lsu_done && r_cause != C_NONE;
    assign o_fault_cause = r_cause;
    assign o_lsu_stall   = w_accept || r_state == S_REQ || r_state == S_WAIT;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, random ops against a spec-level model, reset and ignore sequences
module tb_load_store_unit;
    localparam int TMO = 16;
    logic clk = 0, rst_n = 0, start = 0, rd = 0, wr = 0, gnt = 0, rvalid = 0;
    logic [2:0]  f3 = 0;
    logic [31:0] addr = 0, wdata = 0, rdata = 0;
    logic        mem_req, mem_we, done, stall, fault;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_wstrb;
    logic [1:0]  cause;
    int total = 0, passed = 0;
    logic [31:0] m_ld = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_mem_read(rd), .i_mem_write(wr),
        .i_funct3(f3), .i_addr(addr), .i_wdata_in(wdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_load_data(load_data), .o_lsu_done(done), .o_lsu_stall(stall),
        .o_lsu_fault(fault), .o_fault_cause(cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    typedef struct {
        logic rd, wr; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
        int g, rv; logic [31:0] ld; logic [1:0] cause; logic [3:0] strb; logic [31:0] wd;
    } vec_t;

    // Spec-level reference: sizes, legality and extension from plain arithmetic.
    task automatic model(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd_in, input logic [31:0] rd_in, input int rv,
                         output logic [1:0] c, output logic [3:0] s, output logic [31:0] wd);
        int sz = (f[1:0] == 0) ? 1 : (f[1:0] == 1) ? 2 : 4;
        bit ill = (r && w) || (r ? !(f inside {0, 1, 2, 4, 5}) : (f > 2));
        bit mis = (a % sz) != 0;
        longint v;
        c = ill ? 2'd2 : mis ? 2'd1 : (r && rv > TMO) ? 2'd3 : 2'd0;
        s = (w && c == 0) ? 4'(((1 << sz) - 1) << (a % 4)) : 4'd0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wd_in[8*(i % sz) +: 8];
        if (r && c == 0) begin
            v = (longint'(rd_in) >> (8 * (a % 4))) & ((longint'(1) << (8 * sz)) - 1);
            if (sz < 4 && !f[2] && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
            m_ld = 32'(v);
        end
    endtask

    task automatic run_op(input vec_t t);
        int done_j = 0, ndone = 0, nreq = 0, gnt_j = 0, exp_j;
        bit stable = 1, stall_ok = 1;
        logic [31:0] a0 = 0, w0 = 0, ld = 0;
        logic [3:0] s0 = 0;
        logic we0 = 0, flt = 0;
        logic [1:0] cs = 0;
        bit bus = t.cause == 0 || t.cause == 3;
        exp_j = !bus ? 1 : (t.wr || t.rv == 0) ? t.g + 2 : (t.rv <= TMO) ? t.g + 2 + t.rv : t.g + 2 + TMO;
        rd = t.rd; wr = t.wr; f3 = t.f3; addr = t.addr; wdata = t.wdata; rdata = t.rdata; start = 1;
        #1 chk("stall_accept", stall, 1);
        for (int j = 1; j <= 60 && ndone == 0; j++) begin
            @(negedge clk);
            if (j == 1) begin start = 0; rd = 0; wr = 0; f3 = 0; addr = $urandom; wdata = $urandom; end
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we; end
                else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wstrb !== s0 || mem_we !== we0) stable = 0;
            end
            if (done) begin ndone++; done_j = j; ld = load_data; flt = fault; cs = cause; stall_ok &= !stall; end
            else stall_ok &= stall;
            gnt = mem_req && nreq > t.g;
            if (gnt) gnt_j = j;
            rvalid = gnt ? (t.rd && t.rv == 0) : (gnt_j != 0 && !done && j - gnt_j == t.rv);
        end
        gnt = 0; rvalid = 0;
        chk("done_latency", done_j, exp_j);
        chk("req_cycles", nreq, bus ? t.g + 1 : 0);
        chk("stall_shape", stall_ok, 1);
        chk("fault", flt, t.cause != 0);
        chk("cause", cs, t.cause);
        chk("load_data", ld, t.ld);
        if (bus) begin
            chk("mem_addr", a0, t.addr & 32'hFFFF_FFFC);
            chk("mem_we", we0, t.wr);
            chk("mem_wstrb", s0, t.strb);
            chk("req_stable", stable, 1);
            if (t.wr) chk("mem_wdata", w0, t.wd);
        end
        @(negedge clk);
        chk("done_single", done, 0);
        chk("cause_hold", cause, t.cause);
    endtask

    vec_t tab[12];
    initial begin
        tab[0]  = '{1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 0, 4'h0, 0};
        tab[1]  = '{1, 0, 3'b101, 32'h202, 0, 32'h8001_0000, 0, 0, 32'h0000_8001, 0, 4'h0, 0};
        tab[2]  = '{1, 0, 3'b010, 32'h200, 0, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 0, 4'h0, 0};
        tab[3]  = '{0, 1, 3'b000, 32'h3, 32'hAB, 0, 3, 0, 32'hDEAD_BEEF, 0, 4'b1000, 32'hABAB_ABAB};
        tab[4]  = '{0, 1, 3'b010, 32'h6, 32'h1, 0, 0, 0, 32'hDEAD_BEEF, 1, 4'h0, 0};
        tab[5]  = '{1, 0, 3'b011, 32'h0, 0, 32'h5555, 0, 0, 32'hDEAD_BEEF, 2, 4'h0, 0};
        tab[6]  = '{1, 0, 3'b010, 32'h10, 0, 32'h1111_2222, 0, 99, 32'hDEAD_BEEF, 3, 4'h0, 0};
        tab[7]  = '{1, 0, 3'b001, 32'h2, 0, 32'h8000_1234, 2, TMO, 32'hFFFF_8000, 0, 4'h0, 0};
        tab[8]  = '{0, 1, 3'b001, 32'h2, 32'h1234_CDEF, 0, 1, 0, 32'hFFFF_8000, 0, 4'b1100, 32'hCDEF_CDEF};
        tab[9]  = '{1, 1, 3'b010, 32'h0, 32'h7, 32'h9, 0, 0, 32'hFFFF_8000, 2, 4'h0, 0};
        tab[10] = '{0, 1, 3'b100, 32'h0, 32'h7, 0, 0, 0, 32'hFFFF_8000, 2, 4'h0, 0};
        tab[11] = '{1, 0, 3'b100, 32'h1, 0, 32'h0000_9A00, 0, 1, 32'h0000_009A, 0, 4'h0, 0};
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_cause", {fault, cause}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) run_op(tab[i]);
        m_ld = tab[11].ld;

        // start with neither read nor write is dropped silently
        start = 1; rd = 0; wr = 0;
        #1 chk("ignored_stall", stall, 0);
        begin
            int busy = 0;
            for (int j = 0; j < 3; j++) begin @(negedge clk); start = 0; busy += int'(done | mem_req | stall); end
            chk("ignored_quiet", busy, 0);
        end

        for (int i = 0; i < 40; i++) begin
            vec_t t;
            logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            int k = $urandom_range(0, 9);
            int sel = $urandom_range(0, 5);
            t.rd = k < 5 || k == 9; t.wr = k >= 5;
            t.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
                   t.rd ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
            t.g = $urandom_range(0, 3);
            t.rv = sel == 0 ? 0 : sel == 1 ? 1 : sel == 2 ? $urandom_range(2, 15) :
                   sel == 3 ? TMO : sel == 4 ? TMO + 1 : $urandom_range(0, 3);
            model(t.rd, t.wr, t.f3, t.addr, t.wdata, t.rdata, t.rv, t.cause, t.strb, t.wd);
            t.ld = m_ld;
            run_op(t);
        end

        // asynchronous reset while waiting for read data
        rd = 1; f3 = 3'b010; addr = 32'h40; start = 1;
        @(negedge clk); start = 0; rd = 0; gnt = 1;
        @(negedge clk); gnt = 0;
        chk("wait_before_rst", {mem_req, stall}, 2'b01);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ld", load_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        begin
            vec_t t = '{1, 0, 3'b010, 32'h44, 0, 32'h1357_9BDF, 0, 1, 32'h1357_9BDF, 0, 4'h0, 0};
            run_op(t);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
